fetch_queue: RTL
================

Name: fetch_queue

Overview:
- Parametrised successor to the single-cycle fetch stage.
- Decouples PC generation from decode using a prefetch queue of PC/instruction pairs.
- Talks to an instruction memory over a valid/ready request channel and an in-order response channel of variable latency.
- Handles execute-stage redirects, decode back-pressure (stall_f) and discarding of stale in-flight responses.

Parameters:
- DATA_WIDTH, 32, instruction width.
- ADDRESS_WIDTH, 32, PC / memory address width.
- DEPTH, 4, prefetch queue entries; power of two, ≥2.
- RESET_PC, 0, PC loaded on reset and on pc_src_e = 2'b10.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- stall_f  in  1  decode cannot accept; hold the queue head.
- pc_src_e  in  2  redirect select: 00 sequential, 01 pc_target_e, 10 RESET_PC, 11 treated as 00.
- pc_target_e  in  ADDRESS_WIDTH  redirect target when pc_src_e = 01.
- imem_req_valid  out  1  request to instruction memory.
- imem_req_addr  out  ADDRESS_WIDTH  request address (= fetch PC).
- imem_req_ready  in  1  memory accepts request this cycle.
- imem_resp_valid  in  1  in-order response present.
- imem_resp_data  in  DATA_WIDTH  response instruction.
- valid_f  out  1  queue head valid.
- pc  out  ADDRESS_WIDTH  PC of head instruction.
- pc_plus4  out  ADDRESS_WIDTH  pc + 4, modulo 2^ADDRESS_WIDTH.
- instr  out  DATA_WIDTH  head instruction.

Behaviour:
- State:
  - fetch_pc register.
  - Circular queue of DEPTH {pc, instr} entries with rd_ptr/wr_ptr.
  - occupancy count and outstanding count, each $clog2(DEPTH)+1 bits.
  - drop count: responses to discard.
- Reset:
  - fetch_pc = RESET_PC; all pointers and counts = 0.
  - Outputs: valid_f = 0, imem_req_valid = 0, pc/pc_plus4/instr = 0.
  - Memory is reset with this block; no stale responses survive rst.
- Issue:
  - imem_req_valid = !rst && (occupancy + outstanding < DEPTH) && redirect inactive.
  - imem_req_addr = fetch_pc.
  - On valid && ready: fetch_pc += 4 (wraps), outstanding += 1.
- Response:
  - On imem_resp_valid, outstanding -= 1.
  - If drop > 0: drop -= 1, data discarded.
  - Otherwise write {issue PC, data} at wr_ptr; occupancy += 1.
  - Issue PCs are held in a DEPTH-entry tag FIFO paired with outstanding requests.
- Output:
  - Registered head only; no bypass. A response written at edge N gives valid_f = 1 after edge N.
  - pc, pc_plus4 and instr come from the head entry; they are held stable while stall_f = 1.
- Pop:
  - Occurs when valid_f && !stall_f; rd_ptr advances.
  - Pop and push in the same cycle leave occupancy unchanged.
- Redirect (pc_src_e ∈ {01, 10}) has priority over everything else in that cycle:
  - fetch_pc = pc_target_e or RESET_PC.
  - Queue flushed: occupancy = 0, rd_ptr = wr_ptr.
  - drop = outstanding after this cycle's response (a response arriving this cycle is discarded).
  - No request issued this cycle; pop is ignored.
- Full / empty: never overflows. When occupancy + outstanding = DEPTH, imem_req_valid = 0. valid_f = 0 when empty.
- Pointer wrap: pointers wrap modulo DEPTH.
- Reset mid-operation: immediate return to reset state regardless of outstanding requests.
- Alignment: pc_target_e is assumed 4-byte aligned; bits [1:0] pass through unchecked.

Test Plan:
- Reset release, memory ready=1, 1-cycle latency, stall_f = 0 → requests 0x0, 0x4, 0x8…; valid_f first high 2 cycles after rst falls with pc = 0x0, pc_plus4 = 0x4; then one instruction per cycle.
- stall_f held high for 10 cycles, DEPTH = 4 → exactly 4 entries fill; imem_req_valid = 0 once occupancy + outstanding = 4; head pc/instr unchanged; release drains in order 0x0, 0x4, 0x8, 0xC.
- Redirect pc_src_e = 01, pc_target_e = 0x100 with 2 requests outstanding at 3-cycle latency → both stale responses dropped; next valid_f shows pc = 0x100, pc_plus4 = 0x104.
- pc_src_e = 10 mid-stream → queue flushed; next head pc = RESET_PC.
- imem_req_ready random 50%, variable latency 1–4, ADDRESS_WIDTH = 16 starting at 0xFFF8 → sequential PCs with no gaps or duplicates; wrap 0xFFFC → 0x0000.
- rst asserted with queue full and 2 outstanding → next cycle valid_f = 0, imem_req_valid = 0; after release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_queue.sv
// Prefetch queue that decouples PC generation from decode.
// Owns the instruction-memory request/response channels, redirect flushing and stale-response dropping.
module fetch_queue #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDRESS_WIDTH = 32,
   parameter int DEPTH = 4,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall_f,
   input  logic [1:0]               pc_src_e,
   input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
   output logic                     imem_req_valid,
   output logic [ADDRESS_WIDTH-1:0] imem_req_addr,
   input  logic                     imem_req_ready,
   input  logic                     imem_resp_valid,
   input  logic [DATA_WIDTH-1:0]    imem_resp_data,
   output logic                     valid_f,
   output logic [ADDRESS_WIDTH-1:0] pc,
   output logic [ADDRESS_WIDTH-1:0] pc_plus4,
   output logic [DATA_WIDTH-1:0]    instr
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [ADDRESS_WIDTH-1:0] FOUR = ADDRESS_WIDTH'(4);

   logic [ADDRESS_WIDTH-1:0] fetch_pc;
   logic [ADDRESS_WIDTH-1:0] pc_q    [DEPTH];
   logic [DATA_WIDTH-1:0]    instr_q [DEPTH];
   logic [ADDRESS_WIDTH-1:0] tag_q   [DEPTH];
   logic [PW-1:0]            rd_ptr, wr_ptr, tag_rd, tag_wr;
   logic [CW-1:0]            occ, outst, drop, in_use;
   logic                     redirect, issue, push, pop;

   // Outstanding requests reserve queue slots so every response has a home.
   assign redirect       = (pc_src_e == 2'b01) || (pc_src_e == 2'b10);
   assign in_use         = occ + outst;
   assign imem_req_valid = !rst && (in_use < DEPTH_C) && !redirect;
   assign imem_req_addr  = fetch_pc;
   assign issue          = imem_req_valid && imem_req_ready;
   assign push           = imem_resp_valid && (drop == '0) && !redirect;
   assign valid_f        = (occ != '0);
   assign pop            = valid_f && !stall_f && !redirect;

   assign pc       = valid_f ? pc_q[rd_ptr] : '0;
   assign pc_plus4 = valid_f ? pc_q[rd_ptr] + FOUR : '0;
   assign instr    = valid_f ? instr_q[rd_ptr] : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_pc <= RESET_PC;
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         tag_rd   <= '0;
         tag_wr   <= '0;
         occ      <= '0;
         outst    <= '0;
         drop     <= '0;
      end else begin
         outst <= outst + CW'(issue) - CW'(imem_resp_valid);
         if (imem_resp_valid) tag_rd <= tag_rd + PW'(1);
         if (issue) tag_wr <= tag_wr + PW'(1);
         if (redirect) begin
            // Everything still in flight after this cycle belongs to the old stream.
            fetch_pc <= (pc_src_e == 2'b01) ? pc_target_e : RESET_PC;
            occ      <= '0;
            rd_ptr   <= wr_ptr;
            drop     <= outst - CW'(imem_resp_valid);
         end else begin
            if (issue) fetch_pc <= fetch_pc + FOUR;
            occ <= occ + CW'(push) - CW'(pop);
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            if (imem_resp_valid && (drop != '0)) drop <= drop - CW'(1);
         end
      end
   end

   // Storage arrays carry no reset; occupancy and valid_f qualify their contents.
   always_ff @(posedge clk) begin
      if (issue) tag_q[tag_wr] <= fetch_pc;
      if (push) begin
         pc_q[wr_ptr]    <= tag_q[tag_rd];
         instr_q[wr_ptr] <= imem_resp_data;
      end
   end

endmodule
